// File: rtl/chain_mult_ctrl.sv
// chain_mult_ctrl: multiplies a chain of unsigned operands x0*x1*...*xN-1.
// A single PP_W-bit ripple adder is reused across one shift-and-add step per cycle.
// The running product is truncated to ACC_W bits after every multiply. A sticky flag
// records whether any truncated bit was ever nonzero during the current chain.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand present on in_data
//   in_ready     controller accepts an operand (IDLE / WAIT)
//   in_data      unsigned operand
//   in_last      operand is the final element of the chain
//   out_valid    result available (DONE)
//   out_ready    consumer accepts the result
//   out_product  running product register
//   out_ovf      sticky overflow for the current chain
//   busy         controller is not idle
module chain_mult_ctrl #(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned PP_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_product,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned CntW = (OP_W > 1) ? $clog2(OP_W) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StMul,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [PP_W-1:0]  pp_q, pp_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;

  logic             in_xfer;
  logic             out_xfer;
  logic             mul_last;

  // Shared adder: pp_q + (op bit selected by cnt ? acc shifted by cnt : 0).
  logic [PP_W-1:0]  addend;
  logic [PP_W-1:0]  sum;
  logic [PP_W-1:0]  carry;

  assign addend = op_q[cnt_q] ? (PP_W'(acc_q) << cnt_q) : '0;

  // Ripple chain of full-adder cells. The final carry-out is never formed: an
  // ACC_W x OP_W product always fits in PP_W bits.
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < PP_W; i++) begin : g_fa
    assign sum[i] = pp_q[i] ^ addend[i] ^ carry[i];
    if (i < PP_W - 1) begin : g_cout
      assign carry[i+1] = (pp_q[i] & addend[i]) | (carry[i] & (pp_q[i] ^ addend[i]));
    end
  end

  assign in_ready    = (state_q == StIdle) || (state_q == StWait);
  assign out_valid   = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign out_product = acc_q;
  assign out_ovf     = ovf_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign mul_last = (cnt_q == CntW'(OP_W - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    pp_d    = pp_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          acc_d   = ACC_W'(in_data);
          ovf_d   = 1'b0;
          state_d = in_last ? StDone : StWait;
        end
      end

      StWait: begin
        if (in_xfer) begin
          op_d    = in_data;
          last_d  = in_last;
          pp_d    = '0;
          cnt_d   = '0;
          state_d = StMul;
        end
      end

      StMul: begin
        // Always OP_W steps, even for a zero operand, so latency is data-independent.
        pp_d  = sum;
        cnt_d = cnt_q + CntW'(1);
        if (mul_last) begin
          acc_d   = sum[ACC_W-1:0];
          ovf_d   = ovf_q | (|sum[PP_W-1:ACC_W]);
          state_d = last_q ? StDone : StWait;
        end
      end

      StDone: begin
        if (out_xfer) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      op_q    <= '0;
      pp_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      pp_q    <= pp_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_chain_mult_ctrl.sv
// Scoreboard bench for chain_mult_ctrl: a driver issues operand chains and pushes the
// expected result (product, overflow, latency, stall count); a monitor pops and checks
// whenever the DUT presents a result.
module tb_chain_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        out_ovf;
  logic        busy;

  chain_mult_ctrl #(
    .OP_W (8),
    .ACC_W(16),
    .PP_W (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  typedef struct {
    int t0;
    int prod;
    bit ovf;
    int lat;
    int stall;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] chain_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  bit         mon_busy = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Waits at negedges for in_ready, presenting junk that must be ignored meanwhile.
  task automatic wait_ready(output int waited);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      waited++;
      @(negedge clk);
    end
  endtask

  // Sends chain_q gaplessly; reference: product of operands, truncated each step.
  task automatic run_chain(input int stall);
    int              n;
    int              waited;
    longint unsigned acc;
    longint unsigned p;
    bit              ovf;
    int              t0;
    exp_t            e;
    n   = chain_q.size();
    acc = 0;
    ovf = 0;
    t0  = 0;
    for (int k = 0; k < n; k++) begin
      wait_ready(waited);
      if (!in_ready) begin
        chk("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      if (k > 0) begin
        chk("running_product", out_product, acc);
        chk("running_ovf", out_ovf, ovf);
        chk("ready_low_cycles", waited, (k >= 2) ? 8 : 0);
      end
      in_valid = 1'b1;
      in_data  = chain_q[k];
      in_last  = (k == n - 1);
      if (k == 0) t0 = cyc;
      @(posedge clk);
      if (k == 0) begin
        acc = chain_q[k];
        ovf = 0;
      end else begin
        p = acc * chain_q[k];
        if ((p >> 16) != 0) ovf = 1;
        acc = p % 65536;
      end
      if (k == n - 1) begin
        e.t0    = t0;
        e.prod  = int'(acc);
        e.ovf   = ovf;
        e.lat   = 1 + 9 * (n - 1);
        e.stall = stall;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: pops on the first DONE cycle, checks stability on later ones, drives out_ready.
  initial begin
    exp_t cur;
    int   dcnt;
    bit   after;
    dcnt  = 0;
    after = 0;
    cur.t0 = 0; cur.prod = 0; cur.ovf = 0; cur.lat = 0; cur.stall = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy  = 0;
        after     = 0;
        out_ready = 1'b0;
      end else begin
        if (after) begin
          chk("valid_drop_after_xfer", out_valid, 0);
          chk("ready_back_after_xfer", in_ready, 1);
          after = 0;
        end
        if (out_valid) begin
          if (!mon_busy) begin
            mon_busy = 1;
            dcnt     = 0;
            if (sb.size() == 0) begin
              chk("unexpected_result", sb.size(), 1);
              cur.prod = out_product; cur.ovf = out_ovf; cur.stall = 0;
            end else begin
              cur = sb.pop_front();
              chk("latency", cyc - cur.t0, cur.lat);
              chk("product", out_product, cur.prod);
              chk("ovf", out_ovf, cur.ovf);
            end
          end else begin
            chk("hold_product", out_product, cur.prod);
            chk("hold_ovf", out_ovf, cur.ovf);
            chk("hold_in_ready", in_ready, 0);
          end
          out_ready = (dcnt >= cur.stall);
          dcnt++;
          if (out_ready) begin
            mon_busy = 0;
            after    = 1;
          end
        end else begin
          out_ready = 1'($urandom);
        end
      end
    end
  end

  initial begin
    int w;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", out_product, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);

    chain_q = '{8'd3, 8'd5};                   run_chain(0);
    chain_q = '{8'd2, 8'd3, 8'd4, 8'd5};       run_chain(1);
    chain_q = '{8'd255, 8'd255, 8'd255};       run_chain(2);
    chain_q = '{8'd255, 8'd255, 8'd255, 8'd0}; run_chain(0);
    chain_q = '{8'h7F};                        run_chain(5);
    chain_q = '{8'd6, 8'd7};                   run_chain(0);

    // Reset in the 4th MUL cycle of {200, 9, ...}.
    wait_ready(w);
    in_valid = 1'b1; in_data = 8'd200; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_mul_busy", busy, 1);
    chk("mid_mul_product", out_product, 200);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mulrst_in_ready", in_ready, 1);
    chk("mulrst_out_valid", out_valid, 0);
    chk("mulrst_product", out_product, 0);
    chk("mulrst_ovf", out_ovf, 0);
    chk("mulrst_busy", busy, 0);

    chain_q = '{8'd4, 8'd4}; run_chain(0);

    for (int c = 0; c < 25; c++) begin
      int len;
      len = 1 + int'($urandom_range(0, 4));
      chain_q.delete();
      for (int i = 0; i < len; i++) begin
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0)      chain_q.push_back(8'd0);
        else if (r == 1) chain_q.push_back(8'd255);
        else             chain_q.push_back(8'($urandom));
      end
      run_chain(int'($urandom_range(0, 3)));
    end

    w = 0;
    while ((sb.size() != 0 || mon_busy) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0 || mon_busy) chk("drain_timeout", sb.size() + int'(mon_busy), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
